mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 59 +++++
 rtl/mem_stage_load_align.sv | 32 +++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: the shared pipeline definitions used by the MEM stage.
// It holds the zip widths, the load mem_op encodings and the packed struct
// layouts for each zip. Every struct is MSB first, in the same field order
// as the flat zip buses.
package mem_stage_pkg;

    localparam int EX_ZIP_W  = 106;
    localparam int EXC_ZIP_W = 97;
    localparam int WB_ZIP_W  = 103;
    localparam int FWD_ZIP_W = 39;

    // Load width/extension encodings. Values 101-111 behave as ld.w.
    typedef enum logic [2:0] {
        MEM_LD_W  = 3'b000,
        MEM_LD_B  = 3'b001,
        MEM_LD_H  = 3'b010,
        MEM_LD_BU = 3'b011,
        MEM_LD_HU = 3'b100
    } mem_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        gr_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic [2:0]  mem_op;
    } ex_to_mem_t;

    typedef struct packed {
        logic        csr_re;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [13:0] csr_num;
        logic        ertn_flush;
        logic        inst_syscall;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
    } except_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        gr_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        fwd_we;
        logic        fwd_csr;
        logic [4:0]  rf_waddr;
        logic [31:0] fwd_data;
    } mem_fwd_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks the byte or halfword that the low address bits select
// from the SRAM read word, then sign-extends or zero-extends it as mem_op
// asks. The block is purely combinational.
//   rdata   in  32  raw SRAM read data
//   addr    in  2   alu_result[1:0]
//   mem_op  in  3   load encoding (mem_op_e)
//   data    out 32  aligned and extended load result
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (mem_op)
            MEM_LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LD_H:  data = {{16{half_sel[15]}}, half_sel};
            MEM_LD_BU: data = {24'd0, byte_sel};
            MEM_LD_HU: data = {16'd0, half_sel};
            default:   data = rdata;   // ld.w and the unused encodings
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: the single-cycle MEM pipeline stage. It holds one instruction
// from EX, forms the load write-back data, and passes it to WB together
// with the exception payload and the EX/ID bypass information.
//   clk, rst            clock, synchronous active-high reset
//   EX_to_MEM_valid/zip incoming instruction (106 bits)
//   EX_except_zip       incoming exception/CSR payload (97 bits)
//   data_sram_rdata     load data for the instruction now in MEM
//   WB_allowin          WB can accept this cycle
//   wb_flush            exception or ertn flush from WB
//   MEM_allowin         MEM can accept from EX this cycle
//   MEM_to_WB_zip       {valid, pc, IR, gr_we, rf_waddr, rf_wdata}
//   MEM_except_zip      exception payload, zeroed when output is not valid
//   mem_fwd_zip         {fwd_we, fwd_csr, rf_waddr, fwd_data}
//   mem_ex_block        syscall/ertn in MEM; EX must hold back stores
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EX_to_MEM_valid,
    input  logic [EX_ZIP_W-1:0]  EX_to_MEM_zip,
    input  logic [EXC_ZIP_W-1:0] EX_except_zip,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 WB_allowin,
    input  logic                 wb_flush,
    output logic                 MEM_allowin,
    output logic [WB_ZIP_W-1:0]  MEM_to_WB_zip,
    output logic [EXC_ZIP_W-1:0] MEM_except_zip,
    output logic [FWD_ZIP_W-1:0] mem_fwd_zip,
    output logic                 mem_ex_block
);

    localparam logic MEM_READY_GO = 1'b1;

    logic       valid;
    ex_to_mem_t ex_r;
    except_t    exc_r;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    mem_to_wb_t wb_out;
    mem_fwd_t   fwd_out;

    assign MEM_allowin = !valid || (MEM_READY_GO && WB_allowin);

    // A flush clears valid even while WB is stalling.
    always_ff @(posedge clk) begin
        if (rst || wb_flush)
            valid <= 1'b0;
        else if (MEM_allowin)
            valid <= EX_to_MEM_valid;
    end

    // The payload is not reset, because valid qualifies every use of it.
    always_ff @(posedge clk) begin
        if (MEM_allowin && EX_to_MEM_valid) begin
            ex_r  <= EX_to_MEM_zip;
            exc_r <= EX_except_zip;
        end
    end

    load_align u_load_align (
        .rdata  (data_sram_rdata),
        .addr   (ex_r.alu_result[1:0]),
        .mem_op (ex_r.mem_op),
        .data   (load_data)
    );

    assign rf_wdata = ex_r.res_from_mem ? load_data : ex_r.alu_result;

    always_comb begin
        wb_out.valid    = valid && !wb_flush;
        wb_out.pc       = ex_r.pc;
        wb_out.ir       = ex_r.ir;
        wb_out.gr_we    = ex_r.gr_we;
        wb_out.rf_waddr = ex_r.rf_waddr;
        wb_out.rf_wdata = rf_wdata;
    end

    // CSR reads finish in WB, so fwd_csr makes the consumer stall rather
    // than take fwd_data.
    always_comb begin
        fwd_out.fwd_we   = valid && ex_r.gr_we && (ex_r.rf_waddr != 5'd0);
        fwd_out.fwd_csr  = valid && exc_r.csr_re;
        fwd_out.rf_waddr = ex_r.rf_waddr;
        fwd_out.fwd_data = rf_wdata;
    end

    assign MEM_to_WB_zip  = wb_out;
    assign MEM_except_zip = exc_r & {EXC_ZIP_W{wb_out.valid}};
    assign mem_fwd_zip    = fwd_out;
    assign mem_ex_block   = valid && (exc_r.inst_syscall || exc_r.ertn_flush);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with hand-computed results. The stimulus
// pushes the expected WB output into a scoreboard queue. A monitor pops one
// entry and compares it on every WB handshake.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         EX_to_MEM_valid = 1'b0;
    logic [105:0] EX_to_MEM_zip = '0;
    logic [96:0]  EX_except_zip = '0;
    logic [31:0]  data_sram_rdata = '0;
    logic         WB_allowin = 1'b1;
    logic         wb_flush = 1'b0;
    logic         MEM_allowin;
    logic [102:0] MEM_to_WB_zip;
    logic [96:0]  MEM_except_zip;
    logic [38:0]  mem_fwd_zip;
    logic         mem_ex_block;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [102:0] wb;
        logic [96:0]  exc;
        logic         blk;
        logic [38:0]  fwd;
    } exp_t;

    exp_t sb[$];

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .EX_to_MEM_valid (EX_to_MEM_valid),
        .EX_to_MEM_zip   (EX_to_MEM_zip),
        .EX_except_zip   (EX_except_zip),
        .data_sram_rdata (data_sram_rdata),
        .WB_allowin      (WB_allowin),
        .wb_flush        (wb_flush),
        .MEM_allowin     (MEM_allowin),
        .MEM_to_WB_zip   (MEM_to_WB_zip),
        .MEM_except_zip  (MEM_except_zip),
        .mem_fwd_zip     (mem_fwd_zip),
        .mem_ex_block    (mem_ex_block)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [105:0] mk_ex(input logic [31:0] pc, input logic [31:0] ir,
        input logic we, input logic [4:0] wa, input logic [31:0] alu, input logic rfm,
        input logic [2:0] op);
        return {pc, ir, we, wa, alu, rfm, op};
    endfunction

    function automatic logic [96:0] mk_exc(input logic sys, input logic ertn, input logic [5:0] ec);
        return {1'b0, 1'b0, 32'd0, 32'd0, 14'd0, ertn, sys, ec, 9'd0};
    endfunction

    function automatic exp_t mk_exp(input logic [105:0] ex, input logic [96:0] exc,
        input logic [31:0] wdata);
        exp_t e;
        logic we;
        logic [4:0] wa;
        we    = ex[41];
        wa    = ex[40:36];
        e.wb  = {1'b1, ex[105:74], ex[73:42], we, wa, wdata};
        e.exc = exc;
        e.blk = exc[16] | exc[15];
        e.fwd = {we & (wa != 5'd0), exc[96], wa, wdata};
        return e;
    endfunction

    // The monitor pops one expected entry on every WB handshake.
    always @(negedge clk) begin
        if (!rst && MEM_to_WB_zip[102] && WB_allowin) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got %h expected none", MEM_to_WB_zip);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_zip", 128'(MEM_to_WB_zip), 128'(e.wb));
                chk("except_zip", 128'(MEM_except_zip), 128'(e.exc));
                chk("ex_block", 128'(mem_ex_block), 128'(e.blk));
                chk("fwd_zip", 128'(mem_fwd_zip), 128'(e.fwd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The instruction is accepted on the next edge and shows at WB in the
    // cycle after that. rdata stays applied through that cycle.
    task automatic issue(input logic [105:0] ex, input logic [96:0] exc,
        input logic [31:0] rdata, input logic [31:0] wdata);
        EX_to_MEM_valid = 1'b1;
        EX_to_MEM_zip   = ex;
        EX_except_zip   = exc;
        data_sram_rdata = rdata;
        sb.push_back(mk_exp(ex, exc, wdata));
        step();
        EX_to_MEM_valid = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [105:0] a, b, c;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 128'(MEM_to_WB_zip[102]), 128'd0);
        chk("reset_except", 128'(MEM_except_zip), 128'd0);
        chk("reset_allowin", 128'(MEM_allowin), 128'd1);
        step();

        // Loads: mem_op 0 ld.w, 1 ld.b, 2 ld.h, 3 ld.bu, 4 ld.hu, 5 maps to ld.w.
        issue(mk_ex(32'h100, 32'hA1, 1, 5'd4, 32'h1003, 1, 3'b001), mk_exc(0, 0, 0), 32'h80AA_BBCC, 32'hFFFF_FF80);
        issue(mk_ex(32'h104, 32'hA2, 1, 5'd5, 32'h2002, 1, 3'b100), mk_exc(0, 0, 0), 32'h8001_1234, 32'h0000_8001);
        issue(mk_ex(32'h108, 32'hA3, 1, 5'd6, 32'h2002, 1, 3'b010), mk_exc(0, 0, 0), 32'h8001_1234, 32'hFFFF_8001);
        issue(mk_ex(32'h10C, 32'hA4, 1, 5'd7, 32'h3000, 1, 3'b000), mk_exc(0, 0, 0), 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        issue(mk_ex(32'h110, 32'hA5, 1, 5'd8, 32'h1001, 1, 3'b011), mk_exc(0, 0, 0), 32'h80AA_BBCC, 32'h0000_00BB);
        issue(mk_ex(32'h114, 32'hA6, 1, 5'd9, 32'h1002, 1, 3'b101), mk_exc(0, 0, 0), 32'h1234_5678, 32'h1234_5678);
        // ALU results: r5 forwards, but a write to r0 must not.
        issue(mk_ex(32'h118, 32'hA7, 1, 5'd5, 32'h55, 0, 3'b000), mk_exc(0, 0, 0), 32'hFFFF_FFFF, 32'h55);
        issue(mk_ex(32'h11C, 32'hA8, 1, 5'd0, 32'h77, 0, 3'b000), mk_exc(0, 0, 0), 32'h0, 32'h77);
        // Syscall with ecode 0x0B.
        issue(mk_ex(32'h120, 32'hA9, 0, 5'd0, 32'h0, 0, 3'b000), mk_exc(1, 0, 6'h0B), 32'h0, 32'h0);

        // A WB stall holds A and leaves B waiting.
        a = mk_ex(32'h200, 32'hB1, 1, 5'd10, 32'hAAAA, 0, 3'b000);
        b = mk_ex(32'h204, 32'hB2, 1, 5'd11, 32'hBBBB, 0, 3'b000);
        EX_to_MEM_valid = 1'b1; EX_to_MEM_zip = a; EX_except_zip = '0;
        sb.push_back(mk_exp(a, '0, 32'hAAAA));
        step();
        WB_allowin = 1'b0;
        EX_to_MEM_zip = b;
        sb.push_back(mk_exp(b, '0, 32'hBBBB));
        @(negedge clk);
        chk("stall_allowin", 128'(MEM_allowin), 128'd0);
        chk("stall_hold0", 128'(MEM_to_WB_zip), 128'({1'b1, 32'h200, 32'hB1, 1'b1, 5'd10, 32'hAAAA}));
        step();
        @(negedge clk);
        chk("stall_hold1", 128'(MEM_to_WB_zip), 128'({1'b1, 32'h200, 32'hB1, 1'b1, 5'd10, 32'hAAAA}));
        step();
        WB_allowin = 1'b1;
        step();
        EX_to_MEM_valid = 1'b0;
        step();

        // A flush arriving with an incoming instruction discards it.
        c = mk_ex(32'h300, 32'hC1, 1, 5'd12, 32'hCCCC, 0, 3'b000);
        EX_to_MEM_valid = 1'b1; EX_to_MEM_zip = c; EX_except_zip = mk_exc(1, 0, 6'h0B);
        wb_flush = 1'b1;
        step();
        wb_flush = 1'b0; EX_to_MEM_valid = 1'b0;
        @(negedge clk);
        chk("flush_in_valid", 128'(MEM_to_WB_zip[102]), 128'd0);
        chk("flush_in_except", 128'(MEM_except_zip), 128'd0);
        chk("flush_in_fwd_we", 128'(mem_fwd_zip[38]), 128'd0);
        chk("flush_in_block", 128'(mem_ex_block), 128'd0);
        step();

        // A flush while an instruction sits in MEM masks and then drops it.
        EX_to_MEM_valid = 1'b1; EX_to_MEM_zip = c; EX_except_zip = mk_exc(1, 0, 6'h0B);
        step();
        EX_to_MEM_valid = 1'b0; wb_flush = 1'b1;
        @(negedge clk);
        chk("flush_res_valid", 128'(MEM_to_WB_zip[102]), 128'd0);
        chk("flush_res_except", 128'(MEM_except_zip), 128'd0);
        step();
        wb_flush = 1'b0;
        @(negedge clk);
        chk("flush_res_after", 128'(MEM_to_WB_zip[102]), 128'd0);
        step();

        // A reset in mid-stream drops the resident instruction.
        EX_to_MEM_valid = 1'b1; EX_to_MEM_zip = c; EX_except_zip = '0;
        step();
        EX_to_MEM_valid = 1'b0; rst = 1'b1; WB_allowin = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 128'(MEM_to_WB_zip[102]), 128'd1);
        step();
        rst = 1'b0; WB_allowin = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 128'(MEM_to_WB_zip[102]), 128'd0);
        chk("rst_mid_allowin", 128'(MEM_allowin), 128'd1);
        step();
        step();

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
